// File: rtl/washer_plant_emulator_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : washer_plant_emulator_if
//  Description : Controller <-> washer plant signal bundle.
//                master : the washer controller (drives commands, reads sensors)
//                slave  : the plant emulator  (reads commands, drives sensors)
//  Signals     : motor_on, water_pump_on, drain_valve_on, door_locked,
//                water_level_select[1:0], lid_open_req, lid_close_req,
//                unbalance_inject                  (controller -> plant)
//                lid_closed, water_full, load_balanced, water_level[7:0],
//                drum_speed[3:0], lid_refused, fault_overflow,
//                fault_spin_open                   (plant -> controller)
//  Revision    : 1.0 - initial release
// ============================================================================
interface washer_plant_emulator_if;
    // Commands and user stimulus
    logic       motor_on;
    logic       water_pump_on;
    logic       drain_valve_on;
    logic       door_locked;
    logic [1:0] water_level_select;
    logic       lid_open_req;
    logic       lid_close_req;
    logic       unbalance_inject;
    // Sensors and status
    logic       lid_closed;
    logic       water_full;
    logic       load_balanced;
    logic [7:0] water_level;
    logic [3:0] drum_speed;
    logic       lid_refused;
    logic       fault_overflow;
    logic       fault_spin_open;

    modport master (
        output motor_on, water_pump_on, drain_valve_on, door_locked,
               water_level_select, lid_open_req, lid_close_req, unbalance_inject,
        input  lid_closed, water_full, load_balanced, water_level, drum_speed,
               lid_refused, fault_overflow, fault_spin_open
    );

    modport slave (
        input  motor_on, water_pump_on, drain_valve_on, door_locked,
               water_level_select, lid_open_req, lid_close_req, unbalance_inject,
        output lid_closed, water_full, load_balanced, water_level, drum_speed,
               lid_refused, fault_overflow, fault_spin_open
    );
endinterface
`default_nettype wire

// File: rtl/washer_plant_emulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : washer_plant_emulator
//  Description : Cycle-level emulation of a washing machine plant: water tank
//                with fill pump / drain valve, ramped drum motor, lid with lock
//                interlock, load-balance sensor and two sticky fault flags.
//  Ports       : clk    - system clock, all state on rising edge
//                reset  - synchronous, active-high reset
//                plant  - washer_plant_emulator_if.slave bundle
//                         (commands in, sensors/status out)
//  Parameters  : FILL_STEP  - level increment per cycle with pump on
//                DRAIN_STEP - level decrement per cycle with drain on
//                RAMP_DIV   - cycles per one-step drum speed change
//  Revision    : 1.0 - initial release
// ============================================================================
module washer_plant_emulator #(
    parameter int FILL_STEP  = 4,
    parameter int DRAIN_STEP = 2,
    parameter int RAMP_DIV   = 4
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    washer_plant_emulator_if.slave       plant
);

    localparam int                    C_DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [C_DIV_W-1:0]    C_DIV_LAST = C_DIV_W'(RAMP_DIV - 1);
    localparam logic signed [9:0]     C_FILL     = 10'(FILL_STEP);
    localparam logic signed [9:0]     C_DRAIN    = 10'(DRAIN_STEP);
    localparam logic [3:0]            C_SPD_MAX  = 4'd15;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_ACCEL = 2'd1,
        ST_RUN   = 2'd2,
        ST_DECEL = 2'd3
    } drum_state_t;

    drum_state_t         r_state;
    logic [C_DIV_W-1:0]  r_div;
    logic [3:0]          r_speed;
    logic [7:0]          r_level;
    logic                r_full;
    logic                r_lid_closed;
    logic                r_lid_refused;
    logic                r_balanced;
    logic                r_fault_ovf;
    logic                r_fault_spin;

    logic signed [9:0]   w_sum;
    logic [7:0]          w_next_level;
    logic [7:0]          w_target;
    logic                w_div_tc;

    // ------------------------------------------------------------------
    // Water tank: pump and drain contributions are netted in one signed
    // sum and the result saturated into the 8-bit level range.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum = $signed({2'b00, r_level})
              + (plant.water_pump_on  ? C_FILL  : 10'sd0)
              - (plant.drain_valve_on ? C_DRAIN : 10'sd0);
        if (w_sum < 10'sd0) begin
            w_next_level = 8'd0;
        end else if (w_sum > 10'sd255) begin
            w_next_level = 8'd255;
        end else begin
            w_next_level = w_sum[7:0];
        end
    end

    always_comb begin
        w_target = 8'd64;
        case (plant.water_level_select)
            2'b00:   w_target = 8'd64;
            2'b01:   w_target = 8'd128;
            2'b10:   w_target = 8'd192;
            default: w_target = 8'd240;
        endcase
    end

    // water_full tracks the level being written this edge, so it rises in
    // the same cycle the level reaches the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 8'd0;
            r_full  <= 1'b0;
        end else begin
            r_level <= w_next_level;
            r_full  <= (w_next_level >= w_target);
        end
    end

    // ------------------------------------------------------------------
    // Drum motor ramp FSM
    // ------------------------------------------------------------------
    assign w_div_tc = (r_div == C_DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STOP;
            r_div   <= '0;
            r_speed <= 4'd0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    r_speed <= 4'd0;
                    r_div   <= '0;
                    if (plant.motor_on) begin
                        r_state <= ST_ACCEL;
                    end
                end
                ST_ACCEL: begin
                    if (!plant.motor_on) begin
                        // Reverse mid-ramp: keep the current speed.
                        r_state <= ST_DECEL;
                        r_div   <= '0;
                    end else if (r_speed == C_SPD_MAX) begin
                        // Reachable when DECEL at full speed is reversed.
                        r_state <= ST_RUN;
                        r_div   <= '0;
                    end else if (w_div_tc) begin
                        r_div   <= '0;
                        r_speed <= r_speed + 4'd1;
                        if (r_speed == C_SPD_MAX - 4'd1) begin
                            r_state <= ST_RUN;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_speed <= C_SPD_MAX;
                    r_div   <= '0;
                    if (!plant.motor_on) begin
                        r_state <= ST_DECEL;
                    end
                end
                ST_DECEL: begin
                    if (plant.motor_on) begin
                        r_state <= ST_ACCEL;
                        r_div   <= '0;
                    end else if (r_speed == 4'd0) begin
                        // Reachable when ACCEL at speed 0 is reversed.
                        r_state <= ST_STOP;
                        r_div   <= '0;
                    end else if (w_div_tc) begin
                        r_div   <= '0;
                        r_speed <= r_speed - 4'd1;
                        if (r_speed == 4'd1) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_STOP;
                    r_div   <= '0;
                    r_speed <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lid: an open request wins over a simultaneous close request, but a
    // locked door turns it into a one-cycle refusal pulse instead.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lid_closed  <= 1'b0;
            r_lid_refused <= 1'b0;
        end else begin
            r_lid_refused <= plant.lid_open_req & plant.door_locked;
            if (plant.lid_open_req) begin
                if (!plant.door_locked) begin
                    r_lid_closed <= 1'b0;
                end
            end else if (plant.lid_close_req) begin
                r_lid_closed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load balance: an injected imbalance persists until the drum has
    // come to rest.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_balanced <= 1'b1;
        end else if (plant.unbalance_inject) begin
            r_balanced <= 1'b0;
        end else if (r_state == ST_STOP) begin
            r_balanced <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky faults, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_ovf  <= 1'b0;
            r_fault_spin <= 1'b0;
        end else begin
            if (plant.water_pump_on && (r_level == 8'd255)) begin
                r_fault_ovf <= 1'b1;
            end
            if ((r_speed != 4'd0) && !r_lid_closed) begin
                r_fault_spin <= 1'b1;
            end
        end
    end

    assign plant.water_level     = r_level;
    assign plant.water_full      = r_full;
    assign plant.drum_speed      = r_speed;
    assign plant.lid_closed      = r_lid_closed;
    assign plant.lid_refused     = r_lid_refused;
    assign plant.load_balanced   = r_balanced;
    assign plant.fault_overflow  = r_fault_ovf;
    assign plant.fault_spin_open = r_fault_spin;

endmodule
`default_nettype wire

// File: tb/tb_washer_plant_emulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_washer_plant_emulator
//  Description : Directed self-checking bench for washer_plant_emulator.
//                Expected values are queued as each step is driven and
//                compared after the following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_washer_plant_emulator;

    localparam int FS = 4;
    localparam int DS = 2;

    localparam int S_LVL  = 0;
    localparam int S_FULL = 1;
    localparam int S_SPD  = 2;
    localparam int S_LID  = 3;
    localparam int S_REF  = 4;
    localparam int S_BAL  = 5;
    localparam int S_FOVF = 6;
    localparam int S_FSPN = 7;

    logic clk = 1'b0;
    logic reset;

    washer_plant_emulator_if pif ();

    washer_plant_emulator #(
        .FILL_STEP  (FS),
        .DRAIN_STEP (DS),
        .RAMP_DIV   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .plant (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_lvl;
    bit   m_fovf;

    function automatic logic [31:0] get_obs(int sel);
        case (sel)
            S_LVL:   return 32'(pif.water_level);
            S_FULL:  return 32'(pif.water_full);
            S_SPD:   return 32'(pif.drum_speed);
            S_LID:   return 32'(pif.lid_closed);
            S_REF:   return 32'(pif.lid_refused);
            S_BAL:   return 32'(pif.load_balanced);
            S_FOVF:  return 32'(pif.fault_overflow);
            default: return 32'(pif.fault_spin_open);
        endcase
    endfunction

    function automatic int tgt(logic [1:0] s);
        case (s)
            2'b00:   return 64;
            2'b01:   return 128;
            2'b10:   return 192;
            default: return 240;
        endcase
    endfunction

    task automatic push(string tag, int sel, int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = 32'(val);
        sb.push_back(e);
    endtask

    // Advance one clock and compare every queued expectation.
    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sel);
            n_total++;
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
        end
    endtask

    // One water-tank cycle against the bench's own tank model.
    task automatic water_step(bit p, bit d, string tag);
        int n;
        pif.water_pump_on  = p;
        pif.drain_valve_on = d;
        n = m_lvl + (p ? FS : 0) - (d ? DS : 0);
        if (n < 0)   n = 0;
        if (n > 255) n = 255;
        if (p && m_lvl == 255) m_fovf = 1'b1;
        m_lvl = n;
        push({tag, "_lvl"},  S_LVL,  n);
        push({tag, "_full"}, S_FULL, (n >= tgt(pif.water_level_select)) ? 1 : 0);
        push({tag, "_fovf"}, S_FOVF, int'(m_fovf));
        step();
    endtask

    task automatic push_reset_values(string tag);
        push({tag, "_lvl"},  S_LVL,  0);
        push({tag, "_full"}, S_FULL, 0);
        push({tag, "_spd"},  S_SPD,  0);
        push({tag, "_lid"},  S_LID,  0);
        push({tag, "_ref"},  S_REF,  0);
        push({tag, "_bal"},  S_BAL,  1);
        push({tag, "_fovf"}, S_FOVF, 0);
        push({tag, "_fspn"}, S_FSPN, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset                  = 1'b1;
        pif.motor_on           = 1'b0;
        pif.water_pump_on      = 1'b0;
        pif.drain_valve_on     = 1'b0;
        pif.door_locked        = 1'b0;
        pif.water_level_select = 2'b00;
        pif.lid_open_req       = 1'b0;
        pif.lid_close_req      = 1'b0;
        pif.unbalance_inject   = 1'b0;
        step();
        push_reset_values("rst");
        step();
        reset  = 1'b0;
        m_lvl  = 0;
        m_fovf = 1'b0;

        // Fill to the 128 target: water_full rises with level 128
        pif.water_level_select = 2'b01;
        for (int i = 0; i < 32; i++) water_step(1'b1, 1'b0, "fill128");
        push("fill128_final", S_LVL, 128);
        push("fill128_fullhold", S_FULL, 1);
        pif.water_pump_on = 1'b0;
        step();

        // Pump and drain together net +2; drain alone -2
        repeat (3) water_step(1'b1, 1'b1, "net");
        repeat (2) water_step(1'b0, 1'b1, "drain");

        // Bring level to 250 with target 240, then overflow at the top
        pif.water_level_select = 2'b11;
        while (m_lvl + FS <= 250) water_step(1'b1, 1'b0, "fill240");
        while (m_lvl < 250)       water_step(1'b1, 1'b1, "trim");
        push("at250", S_LVL, 250);
        pif.water_pump_on  = 1'b0;
        pif.drain_valve_on = 1'b0;
        step();
        for (int i = 0; i < 3; i++) water_step(1'b1, 1'b0, "ovf");
        push("ovf_sticky", S_FOVF, 1);
        push("ovf_lvl255", S_LVL, 255);
        pif.water_pump_on = 1'b0;
        step();

        // Drain to empty; level saturates at 0
        while (m_lvl > 0) water_step(1'b0, 1'b1, "empty");
        water_step(1'b0, 1'b1, "empty_sat");
        pif.drain_valve_on = 1'b0;

        // Lid close, locked open refused, unlocked open (with close) wins
        pif.lid_close_req = 1'b1;
        push("lid_close", S_LID, 1);
        step();
        pif.lid_close_req = 1'b0;
        pif.door_locked   = 1'b1;
        pif.lid_open_req  = 1'b1;
        push("locked_lid", S_LID, 1);
        push("locked_ref", S_REF, 1);
        step();
        pif.lid_open_req = 1'b0;
        push("ref_pulse_end", S_REF, 0);
        push("locked_lid2", S_LID, 1);
        step();
        pif.door_locked   = 1'b0;
        pif.lid_open_req  = 1'b1;
        pif.lid_close_req = 1'b1;
        push("both_lid", S_LID, 0);
        push("both_ref", S_REF, 0);
        step();
        pif.lid_open_req = 1'b0;
        push("reclose", S_LID, 1);
        step();
        pif.lid_close_req = 1'b0;

        // Accelerate: entry edge, then +1 every 4 cycles to 15
        pif.motor_on = 1'b1;
        for (int i = 1; i <= 61; i++) begin
            push($sformatf("accel_%0d", i), S_SPD, (i - 1) / 4);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            push("run_hold", S_SPD, 15);
            step();
        end

        // Imbalance during RUN persists through deceleration
        pif.unbalance_inject = 1'b1;
        push("unbal_set", S_BAL, 0);
        step();
        pif.unbalance_inject = 1'b0;
        pif.motor_on         = 1'b0;
        for (int i = 1; i <= 61; i++) begin
            push($sformatf("decel_%0d", i), S_SPD, 15 - (i - 1) / 4);
            push($sformatf("decel_bal_%0d", i), S_BAL, 0);
            step();
        end
        push("stop_bal", S_BAL, 1);
        push("stop_spd", S_SPD, 0);
        push("no_spin_fault", S_FSPN, 0);
        step();

        // Reverse mid-ramp: speed held, divider restarts
        pif.motor_on = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            push($sformatf("rev_up_%0d", i), S_SPD, (i - 1) / 4);
            step();
        end
        pif.motor_on = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push($sformatf("rev_hold_%0d", i), S_SPD, 1);
            step();
        end
        push("rev_down", S_SPD, 0);
        step();

        // Fill to 100, ramp to speed 7, open lid, then reset mid-ACCEL
        pif.water_level_select = 2'b01;
        for (int i = 0; i < 25; i++) water_step(1'b1, 1'b0, "fill100");
        pif.water_pump_on = 1'b0;
        pif.motor_on      = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            push($sformatf("ramp7_%0d", i), S_SPD, (i - 1) / 4);
            step();
        end
        pif.lid_open_req = 1'b1;
        push("open_spin_lid", S_LID, 0);
        push("open_spin_spd", S_SPD, 7);
        push("open_spin_f0", S_FSPN, 0);
        step();
        pif.lid_open_req     = 1'b0;
        pif.unbalance_inject = 1'b1;
        push("spin_fault", S_FSPN, 1);
        push("pre_rst_lvl", S_LVL, 100);
        push("pre_rst_spd", S_SPD, 7);
        push("pre_rst_bal", S_BAL, 0);
        push("pre_rst_fovf", S_FOVF, 1);
        step();
        reset                = 1'b1;
        pif.unbalance_inject = 1'b0;
        pif.water_pump_on    = 1'b1;
        pif.door_locked      = 1'b1;
        pif.lid_open_req     = 1'b1;
        push_reset_values("midrst");
        step();
        reset             = 1'b0;
        pif.water_pump_on = 1'b0;
        pif.lid_open_req  = 1'b0;
        pif.motor_on      = 1'b0;
        push("post_rst_spd", S_SPD, 0);
        push("post_rst_fspn", S_FSPN, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
